// File: rtl/stopwatch_ctrl_pkg.sv
// stopwatch_ctrl_pkg: state encoding and BCD constants shared by the stopwatch blocks
package stopwatch_ctrl_pkg;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;
  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] DIGIT_MAX = 4'd9;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: mod-M counter with enable, sync clear and async reset; tc_o flags count==M-1
module tick_prescaler #(
  parameter int M = 1000,
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [N-1:0] cnt_o,
  output logic         tc_o
);
  logic [N-1:0] cnt_q, cnt_d;
  assign tc_o  = cnt_q == N'(M - 1);
  assign cnt_o = cnt_q;
  always_comb cnt_d = clr_i ? '0 : !en_i ? cnt_q : tc_o ? '0 : cnt_q + N'(1);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: start/stop/clear FSM driving a 3-digit BCD counter, one count per TICK_M cycles
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int TICK_M = 1000,
  parameter int TICK_N = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  output logic [1:0]       state,
  output logic             tick,
  output logic [BCD_W-1:0] d2,
  output logic [BCD_W-1:0] d1,
  output logic [BCD_W-1:0] d0,
  output logic             done
);
  state_t state_q, state_d;
  logic [BCD_W-1:0] d2_q, d1_q, d0_q, d2_d, d1_d, d0_d;
  logic [TICK_N-1:0] pre_cnt;
  logic pre_tc, w0, w1, at_max;
  tick_prescaler #(.M(TICK_M), .N(TICK_N)) u_pre (
    .clk   (clk),
    .reset (reset),
    .en_i  (state_q == S_RUN),
    .clr_i (clear),
    .cnt_o (pre_cnt),
    .tc_o  (pre_tc)
  );
  always_comb assert ({1'b0, pre_cnt} < (TICK_N + 1)'(TICK_M));
  assign tick   = (state_q == S_RUN) && pre_tc;
  assign done   = state_q == S_DONE;
  assign state  = state_q;
  assign {d2, d1, d0} = {d2_q, d1_q, d0_q};
  assign w0     = d0_q == DIGIT_MAX;
  assign w1     = d1_q == DIGIT_MAX;
  assign at_max = w0 && w1 && (d2_q == DIGIT_MAX);
  // a committed tick outranks stop so the count lands before pausing
  always_comb begin
    state_d = state_q;
    {d2_d, d1_d, d0_d} = {d2_q, d1_q, d0_q};
    if (clear) begin
      state_d = S_IDLE;
      {d2_d, d1_d, d0_d} = '0;
    end else if (tick) begin
      if (at_max) state_d = S_DONE;
      else begin
        d0_d = w0 ? '0 : d0_q + 4'd1;
        d1_d = w0 ? (w1 ? '0 : d1_q + 4'd1) : d1_q;
        d2_d = (w0 && w1) ? d2_q + 4'd1 : d2_q;
        state_d = stop ? S_PAUSE : S_RUN;
      end
    end else if (stop && state_q == S_RUN) state_d = S_PAUSE;
    else if (start && (state_q == S_IDLE || state_q == S_PAUSE)) state_d = S_RUN;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      {d2_q, d1_q, d0_q} <= '0;
    end else begin
      state_q <= state_d;
      {d2_q, d1_q, d0_q} <= {d2_d, d1_d, d0_d};
    end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: table-driven and hand-sequenced checks of stopwatch_ctrl with TICK_M=4
module tb_stopwatch_ctrl;
  logic clk = 0, reset = 1, start = 0, stop = 0, clear = 0;
  logic [1:0] state;
  logic tick, done;
  logic [3:0] d2, d1, d0;
  int ncmp = 0, nerr = 0;

  stopwatch_ctrl #(.TICK_M(4), .TICK_N(2)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .state(state), .tick(tick), .d2(d2), .d1(d1), .d0(d0), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic s, p, c;
    logic [1:0] st;
    logic tk;
    logic [11:0] d;
  } vec_t;
  vec_t v[20];

  task automatic chk(input string n, input logic [11:0] a, input logic [11:0] e);
    ncmp++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic chk_all(input string n, input logic [1:0] st, input logic tk, input logic [11:0] d);
    chk({n, ".state"}, 12'(state), 12'(st));
    chk({n, ".tick"}, 12'(tick), 12'(tk));
    chk({n, ".done"}, 12'(done), 12'(st == 2'd3));
    chk({n, ".digits"}, {d2, d1, d0}, d);
  endtask

  task automatic step(input logic s, input logic p, input logic c);
    start = s; stop = p; clear = c;
    @(posedge clk); #1;
    start = 0; stop = 0; clear = 0;
  endtask

  task automatic run(input int n);
    repeat (n) step(0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask

  initial begin
    v[0]  = '{1, 0, 0, 2'd1, 0, 12'h000};
    v[1]  = '{0, 0, 0, 2'd1, 0, 12'h000};
    v[2]  = '{0, 0, 0, 2'd1, 0, 12'h000};
    v[3]  = '{0, 0, 0, 2'd1, 1, 12'h000};
    v[4]  = '{0, 0, 0, 2'd1, 0, 12'h001};
    v[5]  = '{0, 1, 0, 2'd2, 0, 12'h001};
    v[6]  = '{1, 1, 0, 2'd1, 0, 12'h001};
    v[7]  = '{0, 0, 0, 2'd1, 0, 12'h001};
    v[8]  = '{1, 1, 0, 2'd2, 0, 12'h001};
    v[9]  = '{0, 0, 0, 2'd2, 0, 12'h001};
    v[10] = '{1, 0, 0, 2'd1, 1, 12'h001};
    v[11] = '{0, 1, 0, 2'd2, 0, 12'h002};
    v[12] = '{1, 0, 1, 2'd0, 0, 12'h000};
    v[13] = '{1, 0, 0, 2'd1, 0, 12'h000};
    v[14] = '{0, 0, 0, 2'd1, 0, 12'h000};
    v[15] = '{1, 0, 1, 2'd0, 0, 12'h000};
    v[16] = '{1, 0, 0, 2'd1, 0, 12'h000};
    v[17] = '{1, 0, 0, 2'd1, 0, 12'h000};
    v[18] = '{0, 1, 0, 2'd2, 0, 12'h000};
    v[19] = '{0, 0, 1, 2'd0, 0, 12'h000};

    do_reset();
    chk_all("reset", 2'd0, 0, 12'h000);
    for (int i = 0; i < 20; i++) begin
      step(v[i].s, v[i].p, v[i].c);
      chk_all($sformatf("vec%0d", i), v[i].st, v[i].tk, v[i].d);
    end

    do_reset();
    step(1, 0, 0);
    run(3);
    chk_all("latency_pre", 2'd1, 1, 12'h000);
    run(1);
    chk_all("latency_first", 2'd1, 0, 12'h001);
    run(36);
    chk_all("forty_edges", 2'd1, 0, 12'h010);
    run(1);
    step(0, 1, 0);
    run(10);
    chk_all("paused_hold", 2'd2, 0, 12'h010);
    step(1, 0, 0);
    chk_all("resume", 2'd1, 0, 12'h010);
    step(0, 0, 0);
    chk_all("resume_phase", 2'd1, 1, 12'h010);
    step(0, 0, 0);
    chk_all("resume_incr", 2'd1, 0, 12'h011);

    do_reset();
    step(1, 0, 0);
    run(4 * 998);
    chk_all("at_998", 2'd1, 0, 12'h998);
    run(4);
    chk_all("at_999", 2'd1, 0, 12'h999);
    run(4);
    chk_all("done", 2'd3, 0, 12'h999);
    step(1, 0, 0);
    chk_all("done_start_ign", 2'd3, 0, 12'h999);
    step(0, 1, 0);
    run(5);
    chk_all("done_hold", 2'd3, 0, 12'h999);
    step(0, 0, 1);
    chk_all("done_clear", 2'd0, 0, 12'h000);

    do_reset();
    step(1, 0, 0);
    run(36);
    chk_all("at_009", 2'd1, 0, 12'h009);
    run(3);
    step(0, 1, 0);
    chk_all("tick_stop", 2'd2, 0, 12'h010);
    step(1, 0, 0);
    run(3);
    chk_all("pre_tick_clear", 2'd1, 1, 12'h010);
    step(0, 0, 1);
    chk_all("tick_clear", 2'd0, 0, 12'h000);
    run(2);
    chk_all("idle_hold", 2'd0, 0, 12'h000);

    do_reset();
    step(1, 0, 0);
    run(4 * 123 + 3);
    chk_all("at_123", 2'd1, 1, 12'h123);
    #2 reset = 1;
    #1 chk_all("async_reset", 2'd0, 0, 12'h000);
    step(1, 0, 0);
    chk_all("reset_held", 2'd0, 0, 12'h000);
    reset = 0;
    step(1, 0, 0);
    chk_all("post_reset_start", 2'd1, 0, 12'h000);
    run(4);
    chk_all("post_reset_count", 2'd1, 0, 12'h001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter TICK_M, default 1000, meaning clock cycles per count tick (>=2).
REQ-002 SHALL have parameter TICK_N, default 10, meaning prescaler width; 2**TICK_N >= TICK_M.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  single-cycle synchronous command pulse.
REQ-006 SHALL have port stop  input  1  single-cycle synchronous command pulse.
REQ-007 SHALL have port clear  input  1  single-cycle synchronous command pulse.
REQ-008 SHALL have port state  output  2  FSM state: IDLE=0, RUN=1, PAUSE=2, DONE=3.
REQ-009 SHALL have port tick  output  1  high in the cycle a count increment is committed.
REQ-010 SHALL have port d2, d1, d0  output  4 each  BCD digits, d2 most significant, range 000-999.
REQ-011 SHALL have port done  output  1  high while state==DONE.

Function
REQ-012 SHALL use one clock and an asynchronous, active-high reset, as fixed above.
REQ-013 SHALL register state and digits; tick and done SHALL be combinational from registered state only.
REQ-014 SHALL apply command priority clear > stop > start when several are sampled on the same edge.
REQ-015 clear in any state SHALL go to IDLE, zero digits and zero the prescaler on that edge.
REQ-016 start in IDLE or PAUSE SHALL go to RUN; start in RUN or DONE SHALL be ignored.
REQ-017 stop in RUN SHALL go to PAUSE; stop in IDLE, PAUSE or DONE SHALL be ignored.
REQ-018 start+stop together in RUN SHALL go to PAUSE; in PAUSE, start+stop SHALL go to RUN (stop is ignored there).
REQ-019 The prescaler SHALL increment only on edges where state==RUN and SHALL wrap TICK_M-1 -> 0.
REQ-020 The prescaler SHALL hold its value in PAUSE, so phase is preserved across pause/resume.
REQ-021 tick SHALL equal (state==RUN) and (prescaler==TICK_M-1).
REQ-022 On an edge with tick high, d0 SHALL increment; 9 -> 0 SHALL carry into d1, and d1 9 -> 0 SHALL carry into d2.
REQ-023 A tick with digits==999 SHALL leave the digits at 999 and go to DONE on that edge.
REQ-024 A tick coinciding with stop SHALL still be committed, and state SHALL go to PAUSE.
REQ-025 A tick coinciding with clear SHALL be discarded; clear wins.
REQ-026 Latency: after start is sampled at edge E, the first increment SHALL occur at edge E+TICK_M (from prescaler 0).
REQ-027 In DONE only clear or reset SHALL change any register.

Reset
REQ-028 reset SHALL force state=IDLE, prescaler=0 and d2=d1=d0=0 immediately, independent of clk.
REQ-029 Outputs SHALL read state=0, tick=0, done=0, digits 000 while reset is high, including mid-RUN.
REQ-030 The first edge after reset deasserts SHALL process commands normally.

Structure
REQ-031 A shared package SHALL hold the state encoding constants, BCD width (4) and digit maximum (9).
REQ-032 A single sub-module tick_prescaler SHALL be instantiated: mod-TICK_M counter with enable, synchronous clear and asynchronous reset, exposing count and a terminal-count flag.
REQ-033 The FSM, command priority and BCD cascade SHALL live in stopwatch_ctrl.

Verification (TICK_M=4)
REQ-034 Reset, then start pulse -> d0=1 four edges after start, and digits=010 after 40 edges.
REQ-035 stop at prescaler=2, wait 10 cycles, then start -> digits hold while paused, and the next increment comes 2 edges after resume.
REQ-036 Run from 998 -> 999, then the next tick gives DONE, done=1, digits 999; start is then ignored; clear gives IDLE, 000.
REQ-037 In RUN, start+stop on the same edge -> PAUSE; clear+start on the same edge -> IDLE, 000.
REQ-038 Tick+stop on the same edge at digits 009 -> 010 in PAUSE; tick+clear on the same edge -> 000 in IDLE.
REQ-039 Assert reset asynchronously mid-RUN at digits 123 -> all outputs zero and state IDLE before the next clk edge.
